activation_pipe: RTL and testbench

- Parametrised, multi-channel, pipelined activation stage for the neuron datapath.
- Sits between the accumulator/adder tree and the next layer (or the max-selection logic).
- Per channel it maps a signed IN_W-bit accumulation to an OUT_W-bit activation using a fixed-point bit-field select.
- Generalises the fixed 12-to-5 combinational activation: selectable mode (identity / ReLU / saturating ReLU), configurable width, shift and channel count, a valid/ready pipeline, and a clip counter.

---
 rtl/activation_pipe.sv | 168 ++++++++++++++++
 tb/tb_activation_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/activation_pipe.sv
// Two-stage multi-channel activation: fixed-point field select with
// identity / ReLU / saturating ReLU, valid/ready pipeline and clip counter.
module activation_pipe #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 5,
  parameter int SHIFT = 3,
  parameter int CH    = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      clip_count
);

  typedef enum logic [1:0] {
    ACT_ID   = 2'd0,
    ACT_RELU = 2'd1,
    ACT_SAT  = 2'd2
  } act_e;

  typedef struct packed {
    logic [CH*IN_W-1:0] data;
    act_e               act;
  } s1_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               LO_HI   = SHIFT + OUT_W - 1;

  logic                 s1_valid_q, s1_valid_d;
  s1_t                  s1_q, s1_d;
  logic                 out_valid_q, out_valid_d;
  logic [CH*OUT_W-1:0]  out_data_q, out_data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 ready2;
  logic                 load1;
  logic                 load2;
  act_e                 act_in;
  logic [CH*OUT_W-1:0]  act_data;
  logic [CH-1:0]        ch_clip;

  assign ready2   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || ready2;
  assign load1    = in_valid && in_ready;
  assign load2    = s1_valid_q && ready2;

  // 2'b11 folds onto ReLU
  always_comb begin
    act_in = ACT_RELU;
    unique case (1'b1)
      (mode == 2'b00): act_in = ACT_ID;
      (mode == 2'b10): act_in = ACT_SAT;
      default:         act_in = ACT_RELU;
    endcase
  end

  always_comb begin
    s1_d.data = in_data;
    s1_d.act  = act_in;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (load1) begin
      s1_valid_d = 1'b1;
    end else if (load2) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (load1) begin
        s1_q <= s1_d;
      end
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [IN_W-1:0]  x;
    logic             s;
    logic [OUT_W-2:0] f;
    logic             hi_nz;
    logic [OUT_W-1:0] y;
    logic             clip;

    assign x     = s1_q.data[k*IN_W +: IN_W];
    assign s     = x[IN_W-1];
    assign f     = x[SHIFT +: OUT_W-1];
    // bits above the field, sign excluded
    assign hi_nz = |(x[IN_W-2:0] >> LO_HI);

    always_comb begin
      y    = '0;
      clip = 1'b0;
      unique case (s1_q.act)
        ACT_ID: begin
          y = {s, f};
        end
        ACT_SAT: begin
          if (!s && hi_nz) begin
            y    = {1'b0, {(OUT_W-1){1'b1}}};
            clip = 1'b1;
          end else if (!s) begin
            y = {1'b0, f};
          end
        end
        default: begin
          if (!s) begin
            y = {1'b0, f};
          end
        end
      endcase
    end

    assign act_data[k*OUT_W +: OUT_W] = y;
    assign ch_clip[k]                 = clip;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (ready2) begin
      out_valid_d = s1_valid_q;
    end
    if (load2) begin
      out_data_d = act_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (load2 && (|ch_clip) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign clip_count = cnt_q;

endmodule

// File: tb/tb_activation_pipe.sv
// Bench for activation_pipe: directed plan steps plus randomized traffic
// against an arithmetic reference model and an expected-beat queue.
module tb_activation_pipe;

  localparam int IN_W  = 12;
  localparam int OUT_W = 5;
  localparam int SHIFT = 3;
  localparam int CH    = 4;
  localparam int CNT_W = 16;
  localparam int unsigned CMAX = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           mode;
  logic [CH*IN_W-1:0]   in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH*OUT_W-1:0]  out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 clr_cnt;
  logic [CNT_W-1:0]     clip_count;

  activation_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CH(CH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .clr_cnt(clr_cnt),
    .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned clip_exp = 0;
  logic rdy_s;
  logic [CH*OUT_W-1:0] q[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
  endtask

  // Reference: plain integer arithmetic on each channel
  function automatic void model_beat(input logic [CH*IN_W-1:0] d,
                                     input logic [1:0] m,
                                     output logic [CH*OUT_W-1:0] y,
                                     output bit clip);
    y    = '0;
    clip = 1'b0;
    for (int k = 0; k < CH; k++) begin
      int unsigned u, f, hi, v;
      bit neg;
      u   = 32'(d[k*IN_W +: IN_W]);
      neg = u >= (1 << (IN_W-1));
      f   = (u >> SHIFT) % (1 << (OUT_W-1));
      hi  = (u % (1 << (IN_W-1))) >> (SHIFT+OUT_W-1);
      if (m == 2'd0) v = neg ? (1 << (OUT_W-1)) + f : f;
      else if (neg) v = 0;
      else if (m == 2'd2 && hi != 0) begin
        v = (1 << (OUT_W-1)) - 1;
        clip = 1'b1;
      end else v = f;
      y[k*OUT_W +: OUT_W] = OUT_W'(v);
    end
  endfunction

  task automatic tick(output bit acc);
    logic [CH*OUT_W-1:0] y;
    bit c;
    #1;
    rdy_s = in_ready;
    acc = in_valid && in_ready;
    if (out_valid) begin
      check("beat_pending", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        check("out_data", 64'(out_data), 64'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
    if (acc) begin
      model_beat(in_data, mode, y, c);
      q.push_back(y);
      if (c && clip_exp != CMAX) clip_exp++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit a;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick(a);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed_beat(input logic [CH*IN_W-1:0] d,
                               input logic [1:0] m,
                               input logic [CH*OUT_W-1:0] want,
                               input string tag);
    bit a;
    in_valid  = 1'b1;
    in_data   = d;
    mode      = m;
    out_ready = 1'b1;
    tick(a);
    check({tag, "_accept"}, 64'(a), 64'd1);
    in_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick(a);
    #1;
    check({tag, "_lat2"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(want));
    tick(a);
  endtask

  localparam logic [CH*IN_W-1:0] CLIPB = {4{12'h100}};

  initial begin
    bit a;
    int sent;
    rst_n = 1'b0; mode = 2'd0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_clip", 64'(clip_count), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    directed_beat({12'h000, 12'h7FF, 12'hFA0, 12'h058}, 2'd1,
                  {5'h00, 5'h0F, 5'h00, 5'h0B}, "relu");
    check("relu_clip", 64'(clip_count), 64'd0);
    directed_beat({12'h000, 12'h000, 12'h058, 12'hFA0}, 2'd0,
                  {5'h00, 5'h00, 5'h0B, 5'h14}, "ident");
    directed_beat({12'h010, 12'h010, 12'h010, 12'h100}, 2'd2,
                  {5'h02, 5'h02, 5'h02, 5'h0F}, "satrelu");
    drain();
    check("sat_clip1", 64'(clip_count), 64'd1);

    // 8-beat stream with downstream stall on cycles 3..5
    sent = 0;
    for (int i = 0; i < 40 && sent < 8; i++) begin
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      mode      = 2'($urandom_range(0, 3));
      out_ready = !(i >= 3 && i <= 5);
      tick(a);
      if (a) sent++;
      if (i == 4 || i == 5) check("stall_in_ready", 64'(rdy_s), 64'd0);
    end
    check("stall_sent", 64'(sent), 64'd8);
    drain();

    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      for (int k = 0; k < CH; k++)
        in_data[k*IN_W +: IN_W] = ($urandom_range(0, 1) != 0)
          ? IN_W'($urandom) : IN_W'($urandom_range(0, 255));
      mode      = 2'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 3) != 0;
      tick(a);
    end
    drain();
    check("rand_clip", 64'(clip_count), 64'(clip_exp));

    clr_cnt = 1'b1;
    tick(a);
    clr_cnt = 1'b0;
    clip_exp = 0;
    check("clr_idle", 64'(clip_count), 64'd0);

    in_data = CLIPB;
    mode = 2'd2;
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      tick(a);
    end
    drain();
    check("sat_count", 64'(clip_count), 64'hFFFF);
    check("sat_model", 64'(clip_count), 64'(clip_exp));
    directed_beat(CLIPB, 2'd2, {4{5'h0F}}, "sat_extra");
    check("sat_hold", 64'(clip_count), 64'hFFFF);

    // clear lands on the same edge the clipping beat enters stage 2
    in_valid = 1'b1;
    in_data = CLIPB;
    mode = 2'd2;
    tick(a);
    in_valid = 1'b0;
    clr_cnt = 1'b1;
    tick(a);
    clr_cnt = 1'b0;
    drain();
    clip_exp = 0;
    check("clr_wins", 64'(clip_count), 64'd0);

    directed_beat(CLIPB, 2'd2, {4{5'h0F}}, "pre_rst");
    check("pre_rst_clip", 64'(clip_count), 64'd1);
    in_valid = 1'b1;
    tick(a);
    tick(a);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_clip", 64'(clip_count), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    q.delete();
    clip_exp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (6) tick(a);
    check("arst_no_stale", 64'(out_valid), 64'd0);
    check("arst_clip_after", 64'(clip_count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
